z_demux_1to2: RTL and testbench

Registered 1-to-2 stream demultiplexer for the photon-event data path: one valid/ready input stream of `DATA_W`-bit beats framed by a last flag, routed to one of two downstream consumers. The route comes from `iSel`. It is latched on the first beat of each packet and held until that packet's last beat is accepted, so a packet is never split across outputs. Each output has a one-entry register stage, giving 1-cycle latency. The block is the distribution-side counterpart of the 2-to-1 selection logic in the processing board's basic library.

---
 rtl/z_demux_pkg.sv | 11 +
 rtl/z_out_reg.sv | 31 +++
 rtl/z_demux_1to2.sv | 119 +++++++++++
 tb/tb_z_demux_1to2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/z_demux_pkg.sv
// Shared types and constants for the 1-to-2 packet demultiplexer.
package z_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } z_demux_state_t;

  localparam int Z_DEMUX_CNT_W = 16;

endpackage

// File: rtl/z_out_reg.sv
// One-entry valid/ready register stage carrying a data beat and its last flag.
module z_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              iClk,
  input  logic              iRst_N,
  input  logic              iLoad,
  input  logic [DATA_W-1:0] iData,
  input  logic              iLast,
  output logic [DATA_W-1:0] oData,
  output logic              oLast,
  output logic              oValid,
  input  logic              iReady
);

  // A load in the same cycle as a drain wins, so valid stays high at full rate.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      oData  <= '0;
      oLast  <= 1'b0;
      oValid <= 1'b0;
    end else if (iLoad) begin
      oData  <= iData;
      oLast  <= iLast;
      oValid <= 1'b1;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: rtl/z_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer; the route is locked for a whole packet.
// Optional per-output packet counters are built when ZDEMUX_CNT_EN is defined.
//
// Handshake: a beat moves on any rising edge where valid and ready are both 1;
// valid never depends on ready, and data/last hold while valid is 1 and ready 0.
module z_demux_1to2
  import z_demux_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              iClk,
  input  logic              iRst_N,
  input  logic [DATA_W-1:0] iData,
  input  logic              iLast,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iSel,
  output logic [DATA_W-1:0] oData1,
  output logic              oLast1,
  output logic              oValid1,
  input  logic              iReady1,
  output logic [DATA_W-1:0] oData2,
  output logic              oLast2,
  output logic              oValid2,
  input  logic              iReady2,
  output logic              oBusy
`ifdef ZDEMUX_CNT_EN
  ,
  output logic [Z_DEMUX_CNT_W-1:0] oPktCnt1,
  output logic [Z_DEMUX_CNT_W-1:0] oPktCnt2
`endif
);

  z_demux_state_t state;
  z_demux_state_t stateNext;
  logic           selQ;
  logic           route;
  logic           acc;
  logic           load1;
  logic           load2;

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (acc && !iLast) stateNext = LOCK;
      LOCK:    if (acc && iLast)  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // In LOCK the live select is ignored so a packet never splits across outputs.
  always_comb begin
    route = iSel;
    oBusy = 1'b0;
    if (state == LOCK) begin
      route = selQ;
      oBusy = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      selQ <= 1'b0;
    end else if (state == IDLE && acc && !iLast) begin
      selQ <= iSel;
    end
  end

  assign oReady = route ? (~oValid2 | iReady2) : (~oValid1 | iReady1);
  assign acc    = iValid & oReady;
  assign load1  = acc & ~route;
  assign load2  = acc & route;

  z_out_reg #(.DATA_W(DATA_W)) u_out1 (
    .iClk   (iClk),
    .iRst_N (iRst_N),
    .iLoad  (load1),
    .iData  (iData),
    .iLast  (iLast),
    .oData  (oData1),
    .oLast  (oLast1),
    .oValid (oValid1),
    .iReady (iReady1)
  );

  z_out_reg #(.DATA_W(DATA_W)) u_out2 (
    .iClk   (iClk),
    .iRst_N (iRst_N),
    .iLoad  (load2),
    .iData  (iData),
    .iLast  (iLast),
    .oData  (oData2),
    .oLast  (oLast2),
    .oValid (oValid2),
    .iReady (iReady2)
  );

`ifdef ZDEMUX_CNT_EN
  // Counters tick on acceptance of a packet's last beat and wrap naturally.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      oPktCnt1 <= '0;
      oPktCnt2 <= '0;
    end else begin
      if (load1 && iLast) oPktCnt1 <= oPktCnt1 + 1'b1;
      if (load2 && iLast) oPktCnt2 <= oPktCnt2 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_z_demux_1to2.sv
// Scoreboard bench for z_demux_1to2: a packet-level model predicts routing,
// readiness and busy; a monitor pops expected beats as each output hands off.
module tb_z_demux_1to2;

  localparam int DATA_W = 16;

  logic              iClk = 1'b0;
  logic              iRst_N = 1'b0;
  logic [DATA_W-1:0] iData = '0;
  logic              iLast = 1'b0;
  logic              iValid = 1'b0;
  logic              oReady;
  logic              iSel = 1'b0;
  logic [DATA_W-1:0] oData1;
  logic              oLast1;
  logic              oValid1;
  logic              iReady1 = 1'b1;
  logic [DATA_W-1:0] oData2;
  logic              oLast2;
  logic              oValid2;
  logic              iReady2 = 1'b1;
  logic              oBusy;
`ifdef ZDEMUX_CNT_EN
  logic [15:0]       oPktCnt1;
  logic [15:0]       oPktCnt2;
`endif

  z_demux_1to2 #(.DATA_W(DATA_W)) dut (
    .iClk    (iClk),
    .iRst_N  (iRst_N),
    .iData   (iData),
    .iLast   (iLast),
    .iValid  (iValid),
    .oReady  (oReady),
    .iSel    (iSel),
    .oData1  (oData1),
    .oLast1  (oLast1),
    .oValid1 (oValid1),
    .iReady1 (iReady1),
    .oData2  (oData2),
    .oLast2  (oLast2),
    .oValid2 (oValid2),
    .iReady2 (iReady2),
    .oBusy   (oBusy)
`ifdef ZDEMUX_CNT_EN
    ,
    .oPktCnt1 (oPktCnt1),
    .oPktCnt2 (oPktCnt2)
`endif
  );

  always #5 iClk = ~iClk;

  // Expected beats per output, each entry is {last, data}.
  logic [DATA_W:0] exp1_q[$];
  logic [DATA_W:0] exp2_q[$];

  // Packet-level reference state.
  logic        inPkt = 1'b0;
  logic        lockSel = 1'b0;
  logic [15:0] mCnt1 = '0;
  logic [15:0] mCnt2 = '0;

  int nCmp = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen before the rising edge consumes one expected beat.
  always @(negedge iClk) begin
    if (iRst_N) begin
      if (oValid1 && iReady1) begin
        if (exp1_q.size() == 0) check("out1_unexpected", {15'd0, oLast1, oData1}, 32'hFFFF_FFFF);
        else check("out1_beat", {15'd0, oLast1, oData1}, {15'd0, exp1_q.pop_front()});
      end
      if (oValid2 && iReady2) begin
        if (exp2_q.size() == 0) check("out2_unexpected", {15'd0, oLast2, oData2}, 32'hFFFF_FFFF);
        else check("out2_beat", {15'd0, oLast2, oData2}, {15'd0, exp2_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic l,
                       input logic s, input logic r1, input logic r2, output logic accepted);
    logic route;
    logic expReady;
    iValid = v; iData = d; iLast = l; iSel = s; iReady1 = r1; iReady2 = r2;
    @(negedge iClk); #1;
    route    = inPkt ? lockSel : s;
    expReady = route ? (exp2_q.size() == 0 || r2) : (exp1_q.size() == 0 || r1);
    check("oReady", {31'd0, oReady}, {31'd0, expReady});
    check("oBusy", {31'd0, oBusy}, {31'd0, inPkt});
    accepted = v && expReady;
    if (accepted) begin
      if (route) exp2_q.push_back({l, d});
      else       exp1_q.push_back({l, d});
      if (l) begin
        inPkt = 1'b0;
        if (route) mCnt2 = mCnt2 + 16'd1;
        else       mCnt1 = mCnt1 + 16'd1;
      end else if (!inPkt) begin
        inPkt   = 1'b1;
        lockSel = s;
      end
    end
    @(posedge iClk); #1;
  endtask

  task automatic do_reset();
    iValid = 1'b0;
    @(negedge iClk);
    iRst_N = 1'b0;
    #1;
    exp1_q.delete(); exp2_q.delete();
    inPkt = 1'b0; lockSel = 1'b0; mCnt1 = '0; mCnt2 = '0;
    check("rst_valid1", {31'd0, oValid1}, 32'd0);
    check("rst_valid2", {31'd0, oValid2}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_data", {oData1, oData2}, 32'd0);
    check("rst_last", {30'd0, oLast1, oLast2}, 32'd0);
    repeat (2) @(negedge iClk);
    iRst_N = 1'b1;
    @(posedge iClk); #1;
    check("rst_ready", {31'd0, oReady}, 32'd1);
`ifdef ZDEMUX_CNT_EN
    check("rst_cnt", {oPktCnt1, oPktCnt2}, 32'd0);
`endif
  endtask

  logic acc;
  int   nAcc;

  initial begin
    repeat (2) @(posedge iClk);
    do_reset();

    // Single-beat packets to each output.
    cycle(1, 16'h00A5, 1, 0, 1, 1, acc);
    check("single1_acc", {31'd0, acc}, 32'd1);
    check("single1_out", {15'd0, oValid1, oData1}, {15'd0, 1'b1, 16'h00A5});
    cycle(1, 16'h005A, 1, 1, 1, 1, acc);
    check("single2_out", {15'd0, oValid2, oData2}, {15'd0, 1'b1, 16'h005A});
    check("single_busy", {31'd0, oBusy}, 32'd0);
    cycle(0, 16'h0, 0, 0, 1, 1, acc);

    // Locked 4-beat packet while the select toggles every cycle.
    for (int i = 1; i <= 4; i++) begin
      cycle(1, DATA_W'(i), (i == 4), (i % 2 == 1), 1, 1, acc);
      check("lock_acc", {31'd0, acc}, 32'd1);
      check("lock_busy", {31'd0, oBusy}, {31'd0, (i != 4)});
      check("lock_out2", {15'd0, oValid2, oData2}, {15'd0, 1'b1, DATA_W'(i)});
    end
    cycle(0, 16'h0, 0, 0, 1, 1, acc);

    // Backpressure on output 1 must not stall a packet to output 2.
    cycle(1, 16'h1111, 1, 0, 0, 1, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h2222, 1, 0, 0, 1, acc);
      check("bp_blocked", {31'd0, acc}, 32'd0);
      check("bp_hold", {15'd0, oValid1, oData1}, {15'd0, 1'b1, 16'h1111});
    end
    cycle(1, 16'h3333, 0, 1, 0, 1, acc);
    cycle(1, 16'h3334, 1, 0, 0, 1, acc);
    check("bp_pass2", {15'd0, oValid2, oData2}, {15'd0, 1'b1, 16'h3334});
    check("bp_hold_end", {15'd0, oValid1, oData1}, {15'd0, 1'b1, 16'h1111});
    cycle(0, 16'h0, 0, 0, 1, 1, acc);

    // Full-rate 16-beat burst to output 1.
    nAcc = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 16'hB000 + DATA_W'(i), (i == 15), 0, 1, 1, acc);
      if (acc) nAcc++;
      check("burst_valid", {31'd0, oValid1}, 32'd1);
    end
    check("burst_count", nAcc, 32'd16);
    cycle(0, 16'h0, 0, 0, 1, 1, acc);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(9, 0) < 7), DATA_W'($urandom()), ($urandom_range(3, 0) == 0),
            $urandom_range(1, 0), ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0), acc);
    end

    // Reset in the middle of a packet discards it.
    cycle(1, 16'hCAFE, 0, 1, 0, 0, acc);
    cycle(1, 16'hCAFF, 0, 0, 0, 0, acc);
    do_reset();
    cycle(1, 16'h0777, 1, 0, 1, 1, acc);
    check("post_rst_out1", {15'd0, oValid1, oData1}, {15'd0, 1'b1, 16'h0777});

`ifdef ZDEMUX_CNT_EN
    do_reset();
    for (int i = 0; i < 65537; i++) cycle(1, DATA_W'(i), 1, 1, 1, 1, acc);
    check("cnt_wrap2", {16'd0, oPktCnt2}, 32'h0001);
    check("cnt_idle1", {16'd0, oPktCnt1}, 32'h0000);
    check("cnt_model", {oPktCnt1, oPktCnt2}, {mCnt1, mCnt2});
`endif

    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 0, 0, 1, 1, acc);
    check("drain1", exp1_q.size(), 32'd0);
    check("drain2", exp2_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
